// File: rtl/arc4_key_search.sv
// arc4_key_search: steps one arc4 core through candidate keys and reports the
// first key whose decrypted message is entirely printable ASCII (0x20..0x7E).
// A key is abandoned as soon as the core writes one non-printable byte.
module arc4_key_search #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_STEP  = 24'd1,
    parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    input  logic [7:0]  arc_ct_addr,
    output logic        arc_en,
    input  logic        arc_rdy,
    output logic        arc_rst_n,
    output logic [23:0] arc_key,
    input  logic [7:0]  arc_pt_addr,
    input  logic [7:0]  arc_pt_wrdata,
    input  logic        arc_pt_wren
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_LEN,
        S_LATCH_LEN,
        S_START,
        S_RUN,
        S_ABORT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_len;
    logic [23:0] r_cur_key;
    logic [23:0] r_key;
    logic        r_key_valid;
    logic        r_arc_en;
    logic        r_first;

    logic        w_pt_checked;
    logic        w_pt_bad;
    logic [24:0] w_next_key;

    // Only message bytes 1..len are judged; the length byte and overruns are not.
    assign w_pt_checked = arc_pt_wren && (arc_pt_addr != 8'd0) && (arc_pt_addr <= r_len);
    assign w_pt_bad     = w_pt_checked && ((arc_pt_wrdata < 8'h20) || (arc_pt_wrdata > 8'h7E));
    // One extra bit so that stepping past 24'hFFFFFF is seen as exhaustion, not a wrap.
    assign w_next_key   = {1'b0, r_cur_key} + {1'b0, KEY_STEP};

    assign rdy       = (r_state == S_IDLE) || (r_state == S_DONE);
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign arc_en    = r_arc_en;
    assign arc_key   = r_cur_key;
    // The shared ct port belongs to the core only while it may be running.
    assign ct_addr   = ((r_state == S_START) || (r_state == S_RUN)) ? arc_ct_addr : 8'd0;
    // The core is held in reset with the block, and kicked for one cycle on abort.
    assign arc_rst_n = rst_n && (r_state != S_ABORT);

    // Search sequencer: length fetch, per-key launch, monitoring and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= 8'd0;
            r_cur_key   <= KEY_START;
            r_key       <= 24'd0;
            r_key_valid <= 1'b0;
            r_arc_en    <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (en) begin
                        r_state     <= S_READ_LEN;
                        r_key_valid <= 1'b0;
                        r_cur_key   <= KEY_START;
                    end
                end
                S_READ_LEN: begin
                    r_state <= S_LATCH_LEN;
                end
                S_LATCH_LEN: begin
                    r_len <= ct_rddata;
                    if (ct_rddata == 8'd0) begin
                        // An empty message is trivially printable for any key.
                        r_state     <= S_DONE;
                        r_key       <= KEY_START;
                        r_key_valid <= 1'b1;
                    end else begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (arc_rdy) begin
                        r_arc_en <= 1'b1;
                        r_first  <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_arc_en <= 1'b0;
                    r_first  <= 1'b0;
                    // arc_rdy is stale during the launch cycle, so it is not trusted then.
                    if (w_pt_bad) begin
                        r_state <= S_ABORT;
                    end else if (!r_first && arc_rdy) begin
                        r_state     <= S_DONE;
                        r_key       <= r_cur_key;
                        r_key_valid <= 1'b1;
                    end
                end
                S_ABORT: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (w_next_key > {1'b0, KEY_MAX}) begin
                        r_state     <= S_DONE;
                        r_key       <= 24'd0;
                        r_key_valid <= 1'b0;
                    end else begin
                        r_cur_key <= w_next_key[23:0];
                        r_state   <= S_START;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/arc4_key_search.md
Name: arc4_key_search

Overview:
- Sequencer that drives one `arc4` decryption core through a range of candidate 24-bit keys to find a key whose plaintext is entirely printable ASCII.
- Reads the message length from ciphertext memory, starts the core for each key, and watches the core's plaintext writes.
- On the first non-printable byte it aborts that key early; it reports the first key that passes, or "not found".
- Sits between the top-level cracking wrapper and one `arc4` instance. `KEY_START`/`KEY_STEP` let several instances split the key space.

Parameters:
- KEY_START, 24'h000000, first candidate key.
- KEY_STEP, 1, increment between candidate keys (2 for interleaved dual-core search).
- KEY_MAX, 24'hFFFFFF, last key that may be tried (inclusive).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start request; accepted only while rdy=1
- rdy  output  1  high when idle and able to accept en
- key  output  24  key found (valid when key_valid=1)
- key_valid  output  1  1 = key found, 0 = none found or not yet run
- ct_addr  output  8  ciphertext memory address (shared between controller and core)
- ct_rddata  input  8  ciphertext memory read data (synchronous, 1-cycle latency)
- arc_ct_addr  input  8  core's requested ct address
- arc_en  output  1  one-cycle start pulse to core
- arc_rdy  input  1  core idle/done
- arc_rst_n  output  1  core reset (active-low)
- arc_key  output  24  key presented to core
- arc_pt_addr  input  8  core's plaintext write address
- arc_pt_wrdata  input  8  core's plaintext write data
- arc_pt_wren  input  1  core's plaintext write enable

Behaviour:
- Clock, reset and reset values:
  - Single clock, posedge; rst_n is asynchronous and active-low.
  - Reset values: state=IDLE, rdy=1, key=0, key_valid=0, arc_en=0, arc_key=KEY_START, ct_addr=0, internal len=0.
  - arc_rst_n = rst_n AND NOT(state==ABORT), so the core is held in reset while rst_n is low.
- Core contract:
  - arc_en is honoured only when arc_rdy=1.
  - The core drops arc_rdy within 1 cycle of arc_en and raises it again when all len bytes are written.
- ct_addr mux: ct_addr = arc_ct_addr in START/RUN; 0 in all other states.
- States and transitions:
  - IDLE: rdy=1. en=1 -> READ_LEN, with rdy=0, key_valid cleared, cur_key=KEY_START. en while rdy=0 is ignored.
  - READ_LEN: ct_addr=0; one wait cycle -> LATCH_LEN.
  - LATCH_LEN: len <= ct_rddata. If len==0 -> DONE with key=KEY_START, key_valid=1 (core not run). Otherwise -> START.
  - START: wait for arc_rdy=1. Then arc_key=cur_key and arc_en=1 for exactly one cycle -> RUN.
  - RUN: arc_rdy is ignored in the first RUN cycle.
    - Each cycle with arc_pt_wren=1 and 1<=arc_pt_addr<=len, check arc_pt_wrdata against 0x20..0x7E inclusive.
    - Out of range -> ABORT, same cycle decision; later writes are ignored.
    - Writes to address 0 or above len are not checked.
    - arc_rdy=1 (after the first cycle) with no failure -> DONE, key=cur_key, key_valid=1.
    - A failing write in the same cycle that arc_rdy rises takes priority (ABORT).
  - ABORT: arc_rst_n=0 for exactly 1 cycle -> NEXT.
  - NEXT: compute cur_key+KEY_STEP in 25 bits.
    - Result > KEY_MAX -> DONE, key=0, key_valid=0.
    - Otherwise cur_key advances -> START.
  - DONE: rdy=1, results held stable. en=1 -> READ_LEN (new search from KEY_START). key_valid clears on acceptance.
- arc_key holds cur_key from START through ABORT.
- Reset mid-search: immediate return to reset values and the core is reset. There is no resume.
- Latency, len>0, first key passes: rdy falls the cycle after en. Result = 3 + (cycles waiting for arc_rdy) + core run time + 1.

Test Plan:
- Reset: rst_n=0 for 5 cycles -> rdy=1, key_valid=0, arc_en=0, arc_rst_n=0, ct_addr=0. After release, arc_rst_n=1.
- Found on first key: behavioural core model with ct len=3, key 24'h000000 yields bytes 0x48,0x69,0x21; pulse en -> single arc_en pulse with arc_key=0; rdy=1, key_valid=1, key=24'h000000.
- Abort path: model writes 0x03 at pt_addr 1 for key 0, printable for key 1 -> one arc_rst_n low pulse; second arc_en with arc_key=1; final key=1, key_valid=1. No checks on writes after the abort.
- Exhaustion: KEY_START=24'hFFFFFE, KEY_STEP=1, all keys fail -> exactly 2 arc_en pulses; DONE with key_valid=0, key=0. No wrap to 0.
- len=0: ct[0]=0 -> arc_en never pulses; key_valid=1, key=KEY_START within 4 cycles of en.
- Mid-run reset plus restart: assert rst_n=0 in RUN -> outputs return to reset values within the same cycle. Re-run with en -> same result as a clean run. en while rdy=0 causes no second arc_en.
